spi_master_rx: RTL and testbench

- SPI master that reads one DATA_WIDTH-bit sample per frame from the sine-table SPI slave.
- Generates sck and ssel from the system clock and deserialises miso, MSB first.
- Presents the received word as a parallel sample with a one-cycle valid strobe.
- Downstream consumer of the slave; feeds the DAC/processing path in the clk domain.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sck_gen.sv | 38 +++
 rtl/spi_master_rx.sv | 114 +++++++++++
 tb/tb_spi_master_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default sample width.
// Also imported by the sine-table slave side.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: half-period counter, sck register and edge strobes.
// Held at sck=0, count=0 while disabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc   = (cnt == CW'(CLK_DIV - 1));
  assign rise = en & tc & ~sck;
  assign fall = en & tc & sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_rx.sv
// SPI master receiver: one MSB-first word per frame, sampled on sck fall.
// Frame = LOAD (ssel high), SHIFT (data bits), TAIL (slave advances).
module spi_master_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TAIL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sck,
  output logic                  ssel,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int BW   = $clog2(DATA_WIDTH + 1);
  localparam int CMAX = (LOAD_CYCLES > TAIL_CYCLES) ?
                        LOAD_CYCLES : TAIL_CYCLES;
  localparam int CCW  = $clog2(CMAX + 1);

  state_t                state, state_n;
  logic [BW-1:0]         bit_cnt;
  logic [CCW-1:0]        cyc_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  frame_done;
  logic                  fall;
  logic                  rise_unused;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .sck  (sck),
    .rise (rise_unused),
    .fall (fall)
  );

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        if (fall && cyc_cnt == CCW'(LOAD_CYCLES - 1))
          state_n = SHIFT;
      end
      SHIFT: begin
        if (fall && bit_cnt == BW'(DATA_WIDTH - 1))
          state_n = TAIL;
      end
      TAIL: begin
        if (fall && cyc_cnt == CCW'(TAIL_CYCLES - 1)) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ssel and busy follow the next state so they switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel         <= 1'b1;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      ssel         <= !(state_n == SHIFT || state_n == TAIL);
      busy         <= (state_n != IDLE);
      sample_valid <= frame_done;
      if (frame_done) sample <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state_n != state)
        cyc_cnt <= '0;
      else if (fall && (state == LOAD || state == TAIL))
        cyc_cnt <= cyc_cnt + 1'b1;

      if (state != SHIFT)
        bit_cnt <= '0;
      else if (fall)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == SHIFT && fall)
        shreg <= {shreg[DATA_WIDTH-2:0], miso};
    end
  end

endmodule

// File: tb/tb_spi_master_rx.sv
// Bench for spi_master_rx: behavioural table slave, frame-level scoreboard.
// Covers patterns, back-to-back, ignored start, mid-frame reset, fast config.
module tb_spi_master_rx;

  logic        clk = 1'b0;
  logic        rst_n, start, miso;
  logic        sck, ssel, sample_valid, busy;
  logic [11:0] sample;

  logic        start1, miso1;
  logic        sck1, ssel1, valid1, busy1;
  logic [11:0] sample1;

  always #5 clk = ~clk;

  spi_master_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .miso        (miso),
    .sck         (sck),
    .ssel        (ssel),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  spi_master_rx #(
    .CLK_DIV    (2),
    .LOAD_CYCLES(1)
  ) dut_fast (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .miso        (miso1),
    .sck         (sck1),
    .ssel        (ssel1),
    .sample      (sample1),
    .sample_valid(valid1),
    .busy        (busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // table slave: drives bits on sck rise, advances after the tail rise
  logic [11:0] lut [16];
  int ptr = 0;
  int nr = 0;
  int rises_low = 0;
  int exp_idx = 0;
  int vcnt = 0;

  always @(posedge sck or posedge ssel) begin
    if (ssel) nr = 0;
    else begin
      if (nr < 12) miso = lut[ptr % 16][11 - nr];
      nr++;
      if (nr == 13) ptr++;
      rises_low++;
    end
  end

  always @(negedge clk) if (sample_valid) vcnt++;

  logic [11:0] w1;
  int nr1 = 0;

  always @(posedge sck1 or posedge ssel1) begin
    if (ssel1) nr1 = 0;
    else begin
      if (nr1 < 12) miso1 = w1[11 - nr1];
      nr1++;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (!sample_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic frame(input string tag);
    logic [11:0] want;
    int n;
    want = lut[exp_idx % 16];
    @(negedge clk);
    start = 1'b1;
    rises_low = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    wait_valid(n);
    check({tag, "_latency"}, n, 120);
    check({tag, "_sample"}, sample, want);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_ssel_idle"}, ssel, 1);
    check({tag, "_rises"}, rises_low, 13);
    @(posedge clk); #1;
    check({tag, "_valid_1clk"}, sample_valid, 0);
    exp_idx++;
  endtask

  initial begin
    int n, vbase;
    logic [11:0] pats [5];
    pats[0] = 12'hABC; pats[1] = 12'h000; pats[2] = 12'hFFF;
    pats[3] = 12'h001; pats[4] = 12'h800;
    for (int i = 0; i < 16; i++) lut[i] = 12'($urandom);
    for (int i = 0; i < 5; i++) lut[i] = pats[i];
    w1 = 12'($urandom);
    miso = 1'b0; miso1 = 1'b0;
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b0;
    #23;
    check("rst_sck", sck, 0);
    check("rst_ssel", ssel, 1);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) frame($sformatf("f%0d", i));

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!sample_valid && n < 400);
      check($sformatf("b2b%0d_interval", k), n, 121);
      check($sformatf("b2b%0d_sample", k), sample, lut[exp_idx % 16]);
      check($sformatf("b2b%0d_gap", k), {busy, ssel, sck}, 3'b010);
      exp_idx++;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    // start pulsed during SHIFT must be ignored
    vbase = vcnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rises_low = 0;
    n = 0;
    while (rises_low < 3 && n < 400) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_valid(n);
    check("ign_sample", sample, lut[exp_idx % 16]);
    exp_idx++;
    repeat (200) @(posedge clk);
    #1;
    check("ign_one_valid", vcnt - vbase, 1);
    check("ign_idle", busy, 0);

    // reset during SHIFT, then the same entry is re-read
    vbase = vcnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rises_low = 0;
    n = 0;
    while (rises_low < 5 && n < 400) begin @(negedge clk); n++; end
    check("abort_reached", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_sck", sck, 0);
    check("abort_ssel", ssel, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", sample_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_valid", vcnt - vbase, 0);
    frame("reread");

    // fast configuration: CLK_DIV=2, LOAD_CYCLES=1
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!valid1 && n < 400) begin @(posedge clk); #1; n++; end
    check("fast_latency", n, 56);
    check("fast_sample", sample1, w1);
    @(posedge clk); #1;
    check("fast_valid_1clk", valid1, 0);
    check("fast_busy", busy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
